// File: rtl/cell_plotter.sv
// Rasterises one board cell (or clears the whole board) into VGA pixel writes, one pixel per cycle.
// Optional build macro CELL_BORDER_EN darkens the outer ring of each drawn cell.
module cell_plotter #(
   parameter int CELL_SIZE  = 5,
   parameter int ORIGIN_X   = 55,
   parameter int ORIGIN_Y   = 10,
   parameter int BOARD_COLS = 10,
   parameter int BOARD_ROWS = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_col,
   input  logic [4:0] req_row,
   input  logic [5:0] req_colour,
   input  logic       clear_req,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [5:0] colour,
   output logic       plot,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, DRAW, CLEAR, FINISH} state_t;

   localparam logic [8:0] CS    = 9'(CELL_SIZE);
   localparam logic [8:0] OX    = 9'(ORIGIN_X);
   localparam logic [8:0] OY    = 9'(ORIGIN_Y);
   localparam logic [8:0] CLR_W = 9'(BOARD_COLS * CELL_SIZE);
   localparam logic [8:0] CLR_H = 9'(BOARD_ROWS * CELL_SIZE);

   state_t     state, state_nxt;
   logic [3:0] lat_col;
   logic [4:0] lat_row;
   logic [5:0] lat_colour;
   logic [8:0] cnt_x, cnt_y;
   logic [8:0] last_x, last_y;
   logic       row_end, frame_end, in_range, accept_cell;
   logic [8:0] px, py;
   logic [5:0] pix_colour;
   logic       on_ring;

   assign in_range    = (int'(req_col) < BOARD_COLS) && (int'(req_row) < BOARD_ROWS);
   assign accept_cell = (state == IDLE) && !clear_req && req_valid;

   assign last_x    = (state == DRAW) ? CS - 9'd1 : CLR_W - 9'd1;
   assign last_y    = (state == DRAW) ? CS - 9'd1 : CLR_H - 9'd1;
   assign row_end   = (cnt_x == last_x);
   assign frame_end = row_end && (cnt_y == last_y);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clear_req)
               state_nxt = CLEAR;
            else if (req_valid)
               state_nxt = in_range ? DRAW : FINISH;
         end
         DRAW, CLEAR: begin
            if (frame_end)
               state_nxt = FINISH;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_col    <= '0;
         lat_row    <= '0;
         lat_colour <= '0;
         cnt_x      <= '0;
         cnt_y      <= '0;
      end else begin
         if (accept_cell) begin
            lat_col    <= req_col;
            lat_row    <= req_row;
            lat_colour <= req_colour;
         end
         if (state == DRAW || state == CLEAR) begin
            if (row_end) begin
               cnt_x <= '0;
               cnt_y <= frame_end ? 9'd0 : cnt_y + 9'd1;
            end else begin
               cnt_x <= cnt_x + 9'd1;
            end
         end else begin
            cnt_x <= '0;
            cnt_y <= '0;
         end
      end
   end

   // Cell offset only applies in DRAW; CLEAR walks the whole board from the origin.
   always_comb begin
      px = OX + cnt_x;
      py = OY + cnt_y;
      if (state == DRAW) begin
         px = px + 9'(lat_col) * CS;
         py = py + 9'(lat_row) * CS;
      end
   end

   assign on_ring = (cnt_x == 9'd0) || (cnt_x == CS - 9'd1) ||
                    (cnt_y == 9'd0) || (cnt_y == CS - 9'd1);

   always_comb begin
      pix_colour = '0;
      if (state == DRAW) begin
`ifdef CELL_BORDER_EN
         pix_colour = on_ring ? {1'b0, lat_colour[5], 1'b0, lat_colour[3], 1'b0, lat_colour[1]}
                              : lat_colour;
`else
         pix_colour = on_ring ? lat_colour : lat_colour;
`endif
      end
   end

   always_comb begin
      req_ready = (state == IDLE) && !reset;
      done      = (state == FINISH) && !reset;
      plot      = (state == DRAW || state == CLEAR) && !reset;
      x         = plot ? px[7:0] : 8'd0;
      y         = plot ? py[6:0] : 7'd0;
      colour    = plot ? pix_colour : 6'd0;
   end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed checks of cell_plotter: draw vectors, out-of-range requests, clear, and reset mid-draw.
module tb_cell_plotter;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_col;
   logic [4:0] req_row;
   logic [5:0] req_colour;
   logic       clear_req;
   logic [7:0] x;
   logic [6:0] y;
   logic [5:0] colour;
   logic       plot;
   logic       done;

   int total = 0;
   int bad   = 0;

   cell_plotter dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_col   (req_col),
      .req_row   (req_row),
      .req_colour(req_colour),
      .clear_req (clear_req),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .done      (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] col;
      logic [4:0] row;
      logic [5:0] colr;
      logic       clr;
      int         n;
      int         fx;
      int         fy;
      int         w;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0] exp_colour(input logic [5:0] c, input logic clr,
                                             input int cx, input int cy);
      if (clr)
         return 6'd0;
`ifdef CELL_BORDER_EN
      if (cx == 0 || cx == 4 || cy == 0 || cy == 4)
         return {1'b0, c[5], 1'b0, c[3], 1'b0, c[1]};
`else
      if (cx < 0 || cy < 0)
         return 6'd0;
`endif
      return c;
   endfunction

   task automatic run_vec(input int k, input vec_t v);
      int plots = 0;
      int errs  = 0;
      int fin   = 0;
      @(negedge clock);
      chk($sformatf("v%0d_ready_idle", k), int'(req_ready), 1);
      req_valid  = 1'b1;
      clear_req  = v.clr;
      req_col    = v.col;
      req_row    = v.row;
      req_colour = v.colr;
      @(negedge clock);
      // Scramble inputs after acceptance; the latched request must not move.
      req_valid  = 1'b0;
      clear_req  = 1'b0;
      req_col    = ~v.col;
      req_row    = ~v.row;
      req_colour = ~v.colr;
      for (int c = 0; c < 6000 && fin == 0; c++) begin
         if (c > 0)
            @(negedge clock);
         if (req_ready)
            errs++;
         if (plot) begin
            if (done)
               errs++;
            if (int'(x) != v.fx + plots % v.w || int'(y) != v.fy + plots / v.w ||
                colour != exp_colour(v.colr, v.clr, plots % v.w, plots / v.w))
               errs++;
            plots++;
         end else if (done) begin
            fin = 1;
         end else begin
            errs++;
         end
      end
      chk($sformatf("v%0d_done_seen", k), fin, 1);
      chk($sformatf("v%0d_plot_count", k), plots, v.n);
      chk($sformatf("v%0d_pixel_errors", k), errs, 0);
      @(negedge clock);
      chk($sformatf("v%0d_done_one_cycle", k), int'(done), 0);
      chk($sformatf("v%0d_plot_after", k), int'(plot), 0);
      chk($sformatf("v%0d_ready_after", k), int'(req_ready), 1);
   endtask

   initial begin
      vt[0] = '{col: 4'd0,  row: 5'd0,  colr: 6'b110000, clr: 1'b0, n: 25,   fx: 55,  fy: 10,  w: 5};
      vt[1] = '{col: 4'd9,  row: 5'd19, colr: 6'b001011, clr: 1'b0, n: 25,   fx: 100, fy: 105, w: 5};
      vt[2] = '{col: 4'd10, row: 5'd3,  colr: 6'b111111, clr: 1'b0, n: 0,    fx: 0,   fy: 0,   w: 5};
      vt[3] = '{col: 4'd3,  row: 5'd7,  colr: 6'b101010, clr: 1'b0, n: 25,   fx: 70,  fy: 45,  w: 5};
      vt[4] = '{col: 4'd2,  row: 5'd20, colr: 6'b010101, clr: 1'b0, n: 0,    fx: 0,   fy: 0,   w: 5};
      vt[5] = '{col: 4'd15, row: 5'd31, colr: 6'b000011, clr: 1'b0, n: 0,    fx: 0,   fy: 0,   w: 5};
      vt[6] = '{col: 4'd4,  row: 5'd4,  colr: 6'b111111, clr: 1'b1, n: 5000, fx: 55,  fy: 10,  w: 50};
      vt[7] = '{col: 4'd5,  row: 5'd10, colr: 6'b111100, clr: 1'b0, n: 25,   fx: 80,  fy: 60,  w: 5};

      reset      = 1'b1;
      req_valid  = 1'b0;
      clear_req  = 1'b0;
      req_col    = '0;
      req_row    = '0;
      req_colour = '0;
      @(negedge clock);
      @(negedge clock);
      chk("reset_ready", int'(req_ready), 0);
      chk("reset_plot", int'(plot), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_xy", int'(x) + int'(y), 0);
      chk("reset_colour", int'(colour), 0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset_ready", int'(req_ready), 1);

      for (int k = 0; k < 8; k++)
         run_vec(k, vt[k]);

      // Reset on the 10th plot of a draw: no resume, no done.
      begin
         int plots = 0;
         int stray = 0;
         @(negedge clock);
         req_valid  = 1'b1;
         req_col    = 4'd1;
         req_row    = 5'd1;
         req_colour = 6'b001100;
         @(negedge clock);
         req_valid = 1'b0;
         for (int c = 0; c < 40 && plots < 10; c++) begin
            if (c > 0)
               @(negedge clock);
            if (plot)
               plots++;
         end
         chk("rst_mid_reached_10", plots, 10);
         reset = 1'b1;
         @(negedge clock);
         chk("rst_mid_plot", int'(plot), 0);
         chk("rst_mid_done", int'(done), 0);
         chk("rst_mid_ready_in_reset", int'(req_ready), 0);
         reset = 1'b0;
         @(negedge clock);
         chk("rst_mid_ready_after", int'(req_ready), 1);
         for (int c = 0; c < 30; c++) begin
            if (plot || done || !req_ready)
               stray++;
            @(negedge clock);
         end
         chk("rst_mid_no_resume", stray, 0);
      end

      run_vec(8, vt[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
